isa_sequencer: RTL

- Parametrised program sequencer. Next generation of the CryptoCore instruction controller.
- Holds a loadable instruction memory and issues commands to the compute core one at a time, waiting on the core's completion where the instruction requires it.
- Adds over the previous controller:
  - parametrised depth and command width;
  - explicit opcodes: execute-and-wait, fire-and-forget, counted loop, halt;
  - early-done capture;
  - watchdog timeout;
  - pause and abort;
  - a cycle counter that stops at completion.

---
 rtl/isa_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/isa_sequencer.sv
// rtl/isa_sequencer.sv - program sequencer issuing commands to a compute core
module isa_sequencer #(
    parameter int CMD_W      = 64,
    parameter int ADDR_W     = 5,
    parameter int SETTLE_CYC = 2,
    parameter int TIMEOUT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              pause,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [CMD_W+1:0]  prog_din,
    input  logic              done_ins,
    output logic [CMD_W-1:0]  cmd_out,
    output logic              cmd_valid,
    output logic              busy,
    output logic              done_all,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       cycle_count
);
    localparam int IW = CMD_W + 2;
    localparam logic [1:0] OP_EXEC  = 2'b00;
    localparam logic [1:0] OP_ISSUE = 2'b01;
    localparam logic [1:0] OP_LOOP  = 2'b10;
    localparam logic [ADDR_W-1:0] PC_MAX = '1;
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_SETTLE, S_WAIT, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t state, state_n;
    logic [IW-1:0] mem [2**ADDR_W];
    logic [IW-1:0] ins_q;
    logic [1:0] op;
    logic [CMD_W-1:0] payload;
    logic [ADDR_W-1:0] loop_tgt;
    logic [15:0] loop_cnt, loop_rem;
    logic loop_active, jump_pend, sticky, wd_expired;
    logic [15:0] settle_cnt;
    logic [31:0] wd_cnt;

    assign op       = ins_q[IW-1 -: 2];
    assign payload  = ins_q[CMD_W-1:0];
    assign loop_tgt = payload[ADDR_W-1:0];
    assign loop_cnt = payload[ADDR_W+15:ADDR_W];

    assign busy     = !(state inside {S_IDLE, S_DONE, S_ERROR});
    assign done_all = (state == S_DONE);
    assign error    = (state == S_ERROR);

    // ins_q stays stable for the whole instruction because writes are blocked while busy
    always_ff @(posedge clk) begin
        if (prog_we && !busy) mem[prog_addr] <= prog_din;
        ins_q <= mem[pc];
    end

    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == WD_LAST) && !done_ins && !sticky;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_n = S_FETCH;
            S_FETCH:        state_n = S_DECODE;
            S_DECODE: begin
                if (op == OP_EXEC || op == OP_ISSUE) state_n = S_ISSUE;
                else if (op == OP_LOOP)              state_n = S_NEXT;
                else                                 state_n = S_DONE;
            end
            S_ISSUE: begin
                if (op == OP_ISSUE)       state_n = S_NEXT;
                else if (SETTLE_CYC == 0) state_n = S_WAIT;
                else                      state_n = S_SETTLE;
            end
            S_SETTLE: begin
                if (wd_expired)                      state_n = S_ERROR;
                else if (settle_cnt == SETTLE_LAST)  state_n = S_WAIT;
            end
            S_WAIT: begin
                if (done_ins || sticky) state_n = S_NEXT;
                else if (wd_expired)    state_n = S_ERROR;
            end
            S_NEXT: begin
                if (!pause) state_n = (jump_pend || pc != PC_MAX) ? S_FETCH : S_ERROR;
            end
            default: state_n = state;
        endcase
        if (abort) state_n = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            cmd_out     <= '0;
            cmd_valid   <= 1'b0;
            err_code    <= 2'b00;
            cycle_count <= '0;
            loop_active <= 1'b0;
            loop_rem    <= '0;
            jump_pend   <= 1'b0;
            sticky      <= 1'b0;
            settle_cnt  <= '0;
            wd_cnt      <= '0;
        end else begin
            state     <= state_n;
            cmd_valid <= (state == S_ISSUE) && !abort;
            if (abort) begin
                loop_active <= 1'b0;
                loop_rem    <= '0;
                jump_pend   <= 1'b0;
                sticky      <= 1'b0;
                err_code    <= 2'b00;
            end else begin
                if (busy && cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
                case (state)
                    S_IDLE, S_DONE: if (start) begin
                        pc          <= '0;
                        cycle_count <= '0;
                    end
                    S_DECODE: begin
                        jump_pend <= 1'b0;
                        if (op == OP_EXEC || op == OP_ISSUE) cmd_out <= payload;
                        if (op == OP_LOOP) begin
                            if (!loop_active) begin
                                if (loop_cnt != 16'd0) begin
                                    loop_active <= 1'b1;
                                    loop_rem    <= loop_cnt - 16'd1;
                                    jump_pend   <= 1'b1;
                                end
                            end else if (loop_rem != 16'd0) begin
                                loop_rem  <= loop_rem - 16'd1;
                                jump_pend <= 1'b1;
                            end else begin
                                loop_active <= 1'b0;
                            end
                        end
                    end
                    S_ISSUE: begin
                        wd_cnt     <= '0;
                        settle_cnt <= '0;
                        if (done_ins && op == OP_EXEC) sticky <= 1'b1;
                    end
                    S_SETTLE: begin
                        wd_cnt     <= wd_cnt + 32'd1;
                        settle_cnt <= settle_cnt + 16'd1;
                        if (done_ins) sticky <= 1'b1;
                        if (state_n == S_ERROR) err_code <= 2'b01;
                    end
                    S_WAIT: begin
                        wd_cnt <= wd_cnt + 32'd1;
                        if (state_n != S_WAIT) sticky <= 1'b0;
                        if (state_n == S_ERROR) err_code <= 2'b01;
                    end
                    S_NEXT: if (!pause) begin
                        if (jump_pend) begin
                            pc        <= loop_tgt;
                            jump_pend <= 1'b0;
                        end else if (pc != PC_MAX) begin
                            pc <= pc + 1'b1;
                        end else begin
                            err_code <= 2'b10;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
